bits2arr_stream: RTL and testbench
==================================

Name: bits2arr_stream

Overview:
- Inverse of the SIMD result packer: accepts one packed 128-bit vector word and unpacks it into 16 byte lanes.
- Lane i = bits[8i+7:8i], so lane 0 is the least-significant byte.
- Presents the unpacked lanes in parallel, registered and held stable, for the vector register file write-back and operand fetch.
- Also streams the lanes out one byte per cycle, lane 0 first, over a valid/ready handshake to the scalar audio output / FIR tap path.

Parameters:
- LANES, 16, number of byte lanes per packed word.
- LANE_W, 8, bits per lane; packed word width is LANES*LANE_W (128 by default).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_word  input  LANES*LANE_W  packed vector word.
- in_valid  input  1  in_word is valid.
- in_ready  output  1  block can accept a word this cycle.
- out_lanes  output  [LANES-1:0][LANE_W-1:0]  parallel unpacked lanes of the last accepted word.
- out_byte  output  LANE_W  current streamed lane.
- out_idx  output  $clog2(LANES)  lane index of out_byte.
- out_valid  output  1  out_byte is valid.
- out_ready  input  1  downstream consumes out_byte this cycle.
- out_last  output  1  out_byte is lane LANES-1 (qualified by out_valid).
- busy  output  1  streaming in progress (state SEND).

Behaviour:
- Reset values (sync, rst=1 at edge): state=IDLE, in_ready=1, out_valid=0, out_last=0, busy=0, out_idx=0, out_byte=0, out_lanes=all zero, internal shift register and hold buffer cleared.
- Accept: an input handshake is in_valid && in_ready. On accept, in_word is latched. On the next edge, out_lanes updates so that lane i = in_word[8i+7:8i].
- out_lanes changes only on accept; it is held stable through the whole stream and while IDLE.
- FSM IDLE: in_ready=1, out_valid=0. Accept -> SEND; out_byte=lane 0, out_idx=0, out_valid=1 in the cycle after accept (latency 1).
- FSM SEND: out_valid=1; out_byte/out_idx hold while out_ready=0 (no change under backpressure).
- On an output handshake (out_valid && out_ready) with out_idx<LANES-1: advance to lane out_idx+1 at the next edge.
- out_last=1 exactly when out_valid && out_idx==LANES-1.
- Handshake on the last lane: return to IDLE (non-prefetch build), out_valid=0 next cycle, in_ready=1.
- Throughput without prefetch: LANES+1 cycles per word at out_ready=1 (one bubble per word).
- in_ready=0 throughout SEND in the non-prefetch build; in_valid is ignored there.
- Reset mid-stream discards the word in flight: no further out_valid, out_lanes=0.
- out_idx wraps only via the return to lane 0 on a new word; it never exceeds LANES-1.
- No arithmetic on lane data; bits are passed through unmodified. No sign extension.

Optional Feature:
- Macro: BITS2ARR_PREFETCH_EN.
- Defined: adds a one-word hold buffer.
  - In SEND, in_ready=1 while the hold buffer is empty; an accept during SEND fills it.
  - On the last-lane handshake with the buffer full: load the buffered word (out_lanes and stream) at that edge, stay in SEND, and emit lane 0 the next cycle with no bubble. Throughput is LANES cycles/word.
  - Accept and last-lane handshake in the same cycle with the buffer empty: the incoming word goes straight to the stream register, as above.
  - in_ready=0 while the buffer is full.
  - Reset clears the buffer.
- Undefined: no hold buffer; behaviour is exactly as in Behaviour above.

Test Plan:
- Reset then idle: rst=1 two cycles -> in_ready=1, out_valid=0, busy=0, out_lanes all 0x00.
- Accept in_word=128'h0F0E0D0C0B0A09080706050403020100, out_ready=1 -> out_lanes[i]=i next cycle. out_byte streams 0x00..0x0F on 16 consecutive cycles; out_last only with 0x0F; in_ready=1 one cycle after.
- Backpressure: out_ready=0 on lanes 3 and 7 for 4 cycles each -> out_byte holds 0x03/0x07, out_idx holds, no lane skipped or duplicated; total 24 cycles of out_valid.
- in_valid held high with in_word=128'hFF..FF during SEND (non-prefetch) -> in_ready=0, stream and out_lanes unchanged until IDLE, then the word is accepted.
- Reset at lane 5 -> next cycle out_valid=0, out_lanes=0, in_ready=1; a new word streams from lane 0.
- BITS2ARR_PREFETCH_EN, two words A=all 0xAA and B=all 0x55 back-to-back, out_ready=1 -> 32 consecutive out_valid cycles: 16x0xAA then 16x0x55, no gap; out_last twice.

Source files
------------

// File: rtl/bits2arr_stream.sv
// Unpacks a packed LANES*LANE_W vector word into parallel byte lanes and streams them lane 0 first.
// Optional one-word prefetch buffer for bubble-free back-to-back words: BITS2ARR_PREFETCH_EN.
module bits2arr_stream #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned LANE_W = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [LANES*LANE_W-1:0]            in_word,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [LANES-1:0][LANE_W-1:0]       out_lanes,
    output logic [LANE_W-1:0]                  out_byte,
    output logic [$clog2(LANES)-1:0]           out_idx,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_last,
    output logic                               busy
);

    localparam int unsigned W  = LANES * LANE_W;
    localparam int unsigned IW = $clog2(LANES);

    typedef enum logic {
        StIdle,
        StSend
    } state_t;

    state_t                        state;
    logic [LANES-1:0][LANE_W-1:0]  lanes_q;
    logic [W-1:0]                  shreg;
    logic [IW-1:0]                 idx;
    logic                          accept;
    logic                          out_hs;
    logic                          last_hs;

`ifdef BITS2ARR_PREFETCH_EN
    logic [W-1:0]                  hold;
    logic                          hold_full;

    assign in_ready = (state == StIdle) || !hold_full;
`else
    assign in_ready = (state == StIdle);
`endif

    assign out_valid = (state == StSend);
    assign busy      = (state == StSend);
    assign out_last  = out_valid && (idx == IW'(LANES - 1));
    // The current lane always sits at the bottom of the shift register.
    assign out_byte  = shreg[LANE_W-1:0];
    assign out_idx   = idx;
    assign out_lanes = lanes_q;

    assign accept  = in_valid && in_ready;
    assign out_hs  = out_valid && out_ready;
    assign last_hs = out_hs && (idx == IW'(LANES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StIdle;
            lanes_q <= '0;
            shreg   <= '0;
            idx     <= '0;
`ifdef BITS2ARR_PREFETCH_EN
            hold      <= '0;
            hold_full <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
                        lanes_q <= in_word;
                        shreg   <= in_word;
                        idx     <= '0;
                        state   <= StSend;
                    end
                end
                StSend: begin
                    if (last_hs) begin
`ifdef BITS2ARR_PREFETCH_EN
                        if (hold_full) begin
                            lanes_q   <= hold;
                            shreg     <= hold;
                            idx       <= '0;
                            hold_full <= 1'b0;
                        end else if (accept) begin
                            // Word arriving on the last-lane handshake bypasses the buffer.
                            lanes_q <= in_word;
                            shreg   <= in_word;
                            idx     <= '0;
                        end else begin
                            state <= StIdle;
                        end
`else
                        state <= StIdle;
`endif
                    end else if (out_hs) begin
                        shreg <= {{LANE_W{1'b0}}, shreg[W-1:LANE_W]};
                        idx   <= idx + IW'(1);
                    end
`ifdef BITS2ARR_PREFETCH_EN
                    if (accept && !last_hs) begin
                        hold      <= in_word;
                        hold_full <= 1'b1;
                    end
`endif
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bits2arr_stream.sv
// Self-checking bench for bits2arr_stream: word-queue reference model, directed and random stimulus.
module tb_bits2arr_stream;

    localparam int LANES  = 16;
    localparam int LANE_W = 8;
    localparam int W      = LANES * LANE_W;
    localparam int IW     = $clog2(LANES);
`ifdef BITS2ARR_PREFETCH_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic                          clk = 1'b0;
    logic                          rst;
    logic [W-1:0]                  in_word;
    logic                          in_valid;
    logic                          in_ready;
    logic [LANES-1:0][LANE_W-1:0]  out_lanes;
    logic [LANE_W-1:0]             out_byte;
    logic [IW-1:0]                 out_idx;
    logic                          out_valid;
    logic                          out_ready;
    logic                          out_last;
    logic                          busy;

    bits2arr_stream #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_word   (in_word),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_lanes (out_lanes),
        .out_byte  (out_byte),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: words accepted but not fully streamed, head lane position, last finished word.
    logic [W-1:0] wq[$];
    int           pos = 0;
    logic [W-1:0] last_word = '0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge with inputs already driven; compares, then advances one clock.
    task automatic step();
        logic         ev;
        logic         acc;
        logic         hs;
        logic [W-1:0] el;
        ev = (wq.size() > 0);
        el = ev ? wq[0] : last_word;
        check_eq("in_ready", W'(in_ready), W'(wq.size() < CAP));
        check_eq("out_valid", W'(out_valid), W'(ev));
        check_eq("busy", W'(busy), W'(ev));
        check_eq("out_last", W'(out_last), W'(ev && pos == LANES - 1));
        check_eq("out_lanes", W'(out_lanes), el);
        if (ev) begin
            check_eq("out_byte", W'(out_byte), W'(el[pos*LANE_W +: LANE_W]));
            check_eq("out_idx", W'(out_idx), W'(pos));
        end
        acc = in_valid && (wq.size() < CAP);
        hs  = ev && out_ready;
        @(posedge clk);
        if (rst) begin
            wq.delete();
            pos       = 0;
            last_word = '0;
        end else begin
            if (hs) begin
                if (pos == LANES - 1) begin
                    last_word = wq.pop_front();
                    pos       = 0;
                end else begin
                    pos++;
                end
            end
            if (acc) wq.push_back(in_word);
        end
        @(negedge clk);
    endtask

    logic [W-1:0] ramp;
    int           held[LANES];
    int           vcnt;
    int           lcnt;

    initial begin
        for (int i = 0; i < LANES; i++) ramp[i*LANE_W +: LANE_W] = LANE_W'(i);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_word   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_idx", W'(out_idx), W'(0));
        check_eq("rst_byte", W'(out_byte), W'(0));
        step();
        rst = 1'b0;
        step();

        // Ramp word, full throughput.
        in_word   = ramp;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (20) step();

        // Backpressure on lanes 3 and 7, four cycles each.
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < LANES; i++) held[i] = 0;
        vcnt = 0;
        for (int k = 0; k < 30; k++) begin
            out_ready = 1'b1;
            if (wq.size() > 0 && (pos == 3 || pos == 7) && held[pos] < 4) begin
                out_ready = 1'b0;
                held[pos]++;
            end
            vcnt += int'(out_valid);
            step();
        end
        check_eq("bp_valid_cycles", W'(vcnt), W'(24));
        out_ready = 1'b1;

        // All-ones word held on in_valid while the ramp streams.
        in_word  = ramp;
        in_valid = 1'b1;
        step();
        in_word = '1;
        repeat (40) step();
        in_valid = 1'b0;
        repeat (20) step();

        // Reset in the middle of a stream.
        in_word  = ramp;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 40 && !(wq.size() > 0 && pos == 5); k++) step();
        check_eq("mid_idx", W'(out_idx), W'(5));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rst_valid", W'(out_valid), W'(0));
        check_eq("mid_rst_lanes", W'(out_lanes), W'(0));
        check_eq("mid_rst_ready", W'(in_ready), W'(1));
        in_word  = ~ramp;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (20) step();

`ifdef BITS2ARR_PREFETCH_EN
        // Back-to-back words must stream with no bubble.
        vcnt     = 0;
        lcnt     = 0;
        in_word  = {LANES{8'hAA}};
        in_valid = 1'b1;
        step();
        in_word = {LANES{8'h55}};
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            vcnt += int'(out_valid);
            lcnt += int'(out_last);
            step();
        end
        check_eq("pf_valid_cycles", W'(vcnt), W'(31));
        check_eq("pf_last_count", W'(lcnt), W'(2));
`endif

        // Random traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_word   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (40) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
